// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - packet-atomic round-robin merge of FrameLink DMA channels
module dma_channel_arbiter #(
  parameter  int CHANNELS   = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int CNT_WIDTH  = 32,
  localparam int REMW       = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [CHANNELS*DATA_WIDTH-1:0] RX_DATA,
  input  logic [CHANNELS*REMW-1:0]      RX_REM,
  input  logic [CHANNELS-1:0]           RX_SOF_N,
  input  logic [CHANNELS-1:0]           RX_EOF_N,
  input  logic [CHANNELS-1:0]           RX_SRC_RDY_N,
  output logic [CHANNELS-1:0]           RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic [REMW-1:0]               TX_REM,
  output logic                          TX_SOF_N,
  output logic                          TX_EOF_N,
  output logic                          TX_SRC_RDY_N,
  input  logic                          TX_DST_RDY_N,
  output logic [CHW-1:0]                TX_CHANNEL,
  input  logic [CHANNELS-1:0]           ENABLE,
  input  logic                          CNT_CLEAR,
  output logic [CHANNELS*CNT_WIDTH-1:0] PKT_CNT,
  output logic [CHANNELS-1:0]           ERR
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               fsm, fsm_nxt;
  logic [CHW-1:0]       grant, grant_nxt;
  logic [CHW-1:0]       rr_ptr, rr_nxt;
  logic [CHW-1:0]       cand, sel, ic;
  logic                 cand_ok, active, xfer, eof_xfer;
  logic [CHANNELS-1:0]  err_set;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0]  err_q;
  int                   idx;

  // arbitration state; reset leaves rr_ptr on the last channel so channel 0 wins first
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fsm    <= IDLE;
      grant  <= '0;
      rr_ptr <= CHW'(CHANNELS - 1);
    end else begin
      fsm    <= fsm_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // first enabled channel offering a SOF, scanning upward from just past rr_ptr
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    ic      = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      ic  = CHW'(idx);
      if (!cand_ok && ENABLE[ic] && !RX_SRC_RDY_N[ic] && !RX_SOF_N[ic]) begin
        cand_ok = 1'b1;
        cand    = ic;
      end
    end
  end

  // the channel driving TX: the locked owner, else this cycle's candidate
  always_comb begin
    active   = (fsm == LOCKED) || cand_ok;
    sel      = (fsm == IDLE && cand_ok) ? cand : grant;
    xfer     = active && !RX_SRC_RDY_N[sel] && !TX_DST_RDY_N;
    eof_xfer = xfer && !RX_EOF_N[sel];
  end

  // next state: lock on a multi-word start, release and advance rr_ptr on EOF
  always_comb begin
    fsm_nxt   = fsm;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    if (xfer) begin
      if (!RX_EOF_N[sel]) begin
        fsm_nxt = IDLE;
        rr_nxt  = sel;
      end else if (fsm == IDLE) begin
        fsm_nxt   = LOCKED;
        grant_nxt = sel;
      end
    end
  end

  // outputs: zero-latency mux, per-channel handshakes and error events
  always_comb begin
    RX_DST_RDY_N = '1;
    err_set      = '0;
    TX_DATA      = RX_DATA[sel*DATA_WIDTH +: DATA_WIDTH];
    TX_REM       = RX_REM[sel*REMW +: REMW];
    TX_SOF_N     = RX_SOF_N[sel];
    TX_EOF_N     = RX_EOF_N[sel];
    TX_SRC_RDY_N = active ? RX_SRC_RDY_N[sel] : 1'b1;
    TX_CHANNEL   = sel;
    if (active) RX_DST_RDY_N[sel] = TX_DST_RDY_N;
    // a mid-packet word with no owner is dropped immediately so it cannot block the channel
    for (int i = 0; i < CHANNELS; i++) begin
      if (fsm == IDLE && !RX_SRC_RDY_N[i] && RX_SOF_N[i]) begin
        RX_DST_RDY_N[i] = 1'b0;
        err_set[i]      = 1'b1;
      end
    end
    if (fsm == LOCKED && xfer && !RX_SOF_N[grant]) err_set[grant] = 1'b1;
    if (RESET) begin
      TX_SRC_RDY_N = 1'b1;
      RX_DST_RDY_N = '1;
      TX_CHANNEL   = '0;
      err_set      = '0;
    end
  end

  // packet counters and sticky errors; an event in the clear cycle survives the clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (CNT_CLEAR)
          cnt_q[i] <= (eof_xfer && sel == CHW'(i)) ? CNT_WIDTH'(1) : '0;
        else if (eof_xfer && sel == CHW'(i))
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
      err_q <= CNT_CLEAR ? err_set : (err_q | err_set);
    end
  end

  // flatten the counter array onto the output bus
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) PKT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - directed bench with a cycle-level arbitration model
module tb_dma_channel_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int RW  = 3;
  localparam int CHW = 2;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N*DW-1:0] RX_DATA;
  logic [N*RW-1:0] RX_REM;
  logic [N-1:0]    RX_SOF_N, RX_EOF_N, RX_SRC_RDY_N, RX_DST_RDY_N;
  logic [DW-1:0]   TX_DATA;
  logic [RW-1:0]   TX_REM;
  logic            TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N, TX_DST_RDY_N;
  logic [CHW-1:0]  TX_CHANNEL;
  logic [N-1:0]    ENABLE;
  logic            CNT_CLEAR;
  logic [N*CW-1:0] PKT_CNT;
  logic [N-1:0]    ERR;

  dma_channel_arbiter #(.CHANNELS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
    .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N), .TX_CHANNEL(TX_CHANNEL),
    .ENABLE(ENABLE), .CNT_CLEAR(CNT_CLEAR), .PKT_CNT(PKT_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [DW-1:0] data; logic [RW-1:0] rem; bit sof; bit eof; } word_t;
  typedef struct { int ch; logic [DW-1:0] data; int cyc; } txrec_t;

  word_t  q [N][$];
  txrec_t txlog [$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  bit     acc [N];

  bit m_locked;
  int m_owner, m_last;
  int m_cnt [N];
  bit m_err [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_last   = N - 1;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_err[i] = 0; acc[i] = 0; end
  endtask

  task automatic check_cycle();
    int best, bestd, cur, d;
    bit move;
    logic [N-1:0] exp_dst;
    logic exp_src;
    txrec_t r;
    cyc++;
    if (RESET) begin
      model_reset();
      chk("rst_tx_src_rdy", TX_SRC_RDY_N, 1);
      chk("rst_rx_dst_rdy", RX_DST_RDY_N, 4'hF);
      chk("rst_tx_channel", TX_CHANNEL, 0);
      return;
    end
    best = -1;
    bestd = N;
    for (int c = 0; c < N; c++) begin
      if (ENABLE[c] && !RX_SRC_RDY_N[c] && !RX_SOF_N[c]) begin
        d = (c - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin bestd = d; best = c; end
      end
    end
    cur = m_locked ? m_owner : best;
    exp_src = (cur >= 0) ? RX_SRC_RDY_N[cur] : 1'b1;
    exp_dst = '1;
    for (int i = 0; i < N; i++) begin
      if (i == cur) exp_dst[i] = TX_DST_RDY_N;
      else if (!m_locked && !RX_SRC_RDY_N[i] && RX_SOF_N[i]) exp_dst[i] = 1'b0;
    end
    chk("tx_src_rdy", TX_SRC_RDY_N, exp_src);
    chk("rx_dst_rdy", RX_DST_RDY_N, exp_dst);
    chk("tx_channel", TX_CHANNEL, (cur >= 0) ? cur : m_owner);
    if (!exp_src) begin
      chk("tx_data", TX_DATA, RX_DATA[cur*DW +: DW]);
      chk("tx_rem", TX_REM, RX_REM[cur*RW +: RW]);
      chk("tx_sof", TX_SOF_N, RX_SOF_N[cur]);
      chk("tx_eof", TX_EOF_N, RX_EOF_N[cur]);
    end
    for (int i = 0; i < N; i++) begin
      chk("pkt_cnt", PKT_CNT[i*CW +: CW], m_cnt[i]);
      chk("err", ERR[i], m_err[i]);
    end
    if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
      r.ch = int'(TX_CHANNEL);
      r.data = TX_DATA;
      r.cyc = cyc;
      txlog.push_back(r);
    end
    move = (cur >= 0) && !exp_src && !TX_DST_RDY_N;
    for (int i = 0; i < N; i++) acc[i] = !RX_SRC_RDY_N[i] && !exp_dst[i];
    if (CNT_CLEAR)
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_err[i] = 0; end
    for (int i = 0; i < N; i++)
      if (!m_locked && !RX_SRC_RDY_N[i] && RX_SOF_N[i]) m_err[i] = 1;
    if (move) begin
      if (m_locked && !RX_SOF_N[cur]) m_err[cur] = 1;
      if (!RX_EOF_N[cur]) begin
        m_cnt[cur] = (m_cnt[cur] + 1) % (1 << CW);
        m_locked = 0;
        m_last = cur;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner = cur;
      end
    end
  endtask

  initial forever begin
    @(negedge CLK);
    check_cycle();
  end

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        RX_SRC_RDY_N[i] = 1'b0;
        RX_DATA[i*DW +: DW] = q[i][0].data;
        RX_REM[i*RW +: RW] = q[i][0].rem;
        RX_SOF_N[i] = !q[i][0].sof;
        RX_EOF_N[i] = !q[i][0].eof;
      end else begin
        RX_SRC_RDY_N[i] = 1'b1;
        RX_DATA[i*DW +: DW] = '0;
        RX_REM[i*RW +: RW] = '0;
        RX_SOF_N[i] = 1'b1;
        RX_EOF_N[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    present();
  endtask

  task automatic push_word(input int ch, input logic [DW-1:0] data, input int rem, input bit sof, input bit eof);
    word_t w;
    w.data = data;
    w.rem = RW'(rem);
    w.sof = sof;
    w.eof = eof;
    q[ch].push_back(w);
  endtask

  task automatic push_pkt(input int ch, input logic [DW-1:0] base, input int len);
    for (int k = 0; k < len; k++) push_word(ch, base + DW'(k), k, k == 0, k == len - 1);
  endtask

  function automatic bit pending(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i] && q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain(input logic [N-1:0] mask, input int maxc);
    int n = 0;
    while (pending(mask) && n < maxc) begin tick(); n++; end
    checks++;
    if (pending(mask)) begin
      failures++;
      $display("FAIL drain_timeout: channels %b still pending after %0d cycles", mask, maxc);
    end
  endtask

  task automatic log_is(input string name, input int idx, input int ch, input logic [DW-1:0] data, input int gap, input int base);
    if (idx >= txlog.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: tx word %0d missing, only %0d seen, expected ch %0d data %0h", name, idx, txlog.size(), ch, data);
    end else begin
      chk({name, "_ch"}, txlog[idx].ch, ch);
      chk({name, "_data"}, txlog[idx].data, data);
      if (gap >= 0) chk({name, "_cycle"}, txlog[idx].cyc - txlog[base].cyc, gap);
    end
  endtask

  int b;

  initial begin
    RESET = 1'b1;
    TX_DST_RDY_N = 1'b0;
    ENABLE = 4'hF;
    CNT_CLEAR = 1'b0;
    RX_DATA = '0;
    RX_REM = '0;
    present();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_tx_src_rdy", TX_SRC_RDY_N, 1);
    chk("reset_rx_dst_rdy", RX_DST_RDY_N, 4'hF);
    chk("reset_tx_channel", TX_CHANNEL, 0);
    chk("reset_pkt_cnt", PKT_CNT, 0);
    chk("reset_err", ERR, 0);
    RESET = 1'b0;

    // single 3-word packet on channel 0
    b = txlog.size();
    push_pkt(0, 64'hA0, 3);
    present();
    drain(4'h1, 20);
    for (int k = 0; k < 3; k++) log_is("t1", b + k, 0, 64'hA0 + k, k, b);
    chk("t1_pkt_cnt0", PKT_CNT[3:0], 1);

    // four channels contending, fresh round-robin start
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    b = txlog.size();
    for (int i = 0; i < N; i++) push_pkt(i, 64'hC0 + 16 * i, 2);
    present();
    drain(4'hF, 30);
    for (int k = 0; k < 8; k++) log_is("t2", b + k, k / 2, 64'hC0 + 16 * (k / 2) + (k % 2), k, b);
    chk("t2_pkt_cnt", PKT_CNT, 16'h1111);

    // channel 1 disabled while locked; channel 2 takes over; channel 1 held off
    b = txlog.size();
    push_pkt(1, 64'hB0, 3);
    present();
    tick();
    ENABLE = 4'b1101;
    push_pkt(2, 64'hD0, 2);
    push_pkt(1, 64'hB8, 2);
    present();
    drain(4'b0100, 20);
    repeat (3) tick();
    chk("t3_ch1_held", q[1].size(), 2);
    chk("t3_log_len", txlog.size() - b, 5);
    for (int k = 0; k < 3; k++) log_is("t3a", b + k, 1, 64'hB0 + k, k, b);
    for (int k = 0; k < 2; k++) log_is("t3b", b + 3 + k, 2, 64'hD0 + k, 3 + k, b);
    ENABLE = 4'hF;
    drain(4'b0010, 20);
    log_is("t3c", b + 5, 1, 64'hB8, -1, b);
    log_is("t3d", b + 6, 1, 64'hB9, -1, b);
    chk("t3_pkt_cnt", PKT_CNT, 16'h1231);
    chk("t3_err", ERR, 0);

    // downstream stall for 5 cycles in the middle of a packet
    b = txlog.size();
    push_pkt(0, 64'hE0, 4);
    present();
    tick();
    tick();
    TX_DST_RDY_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t4_stall_data", TX_DATA, 64'hE2);
      chk("t4_stall_rem", TX_REM, 2);
      chk("t4_stall_rx_dst", RX_DST_RDY_N, 4'hF);
      chk("t4_stall_cnt", PKT_CNT, 16'h1231);
    end
    TX_DST_RDY_N = 1'b0;
    drain(4'h1, 20);
    log_is("t4a", b, 0, 64'hE0, 0, b);
    log_is("t4b", b + 1, 0, 64'hE1, 1, b);
    log_is("t4c", b + 2, 0, 64'hE2, 7, b);
    log_is("t4d", b + 3, 0, 64'hE3, 8, b);
    chk("t4_pkt_cnt", PKT_CNT, 16'h1232);

    // orphan non-SOF word on channel 3 while idle
    b = txlog.size();
    push_word(3, 64'hF0, 0, 0, 1);
    present();
    #1;
    chk("t5_rx_dst", RX_DST_RDY_N, 4'b0111);
    chk("t5_tx_src", TX_SRC_RDY_N, 1);
    tick();
    #1;
    chk("t5_err", ERR, 4'b1000);
    chk("t5_consumed", q[3].size(), 0);
    chk("t5_no_tx", txlog.size() - b, 0);

    // counter wrap on a 4-bit counter
    CNT_CLEAR = 1'b1;
    tick();
    CNT_CLEAR = 1'b0;
    #1;
    chk("t6_clear_cnt", PKT_CNT, 0);
    chk("t6_clear_err", ERR, 0);
    for (int k = 0; k < 15; k++) push_pkt(0, 64'h100 + k, 1);
    present();
    drain(4'h1, 40);
    chk("t6_cnt_ones", PKT_CNT, 16'h000F);
    push_pkt(0, 64'h110, 1);
    present();
    drain(4'h1, 10);
    chk("t6_cnt_wrap", PKT_CNT, 16'h0000);

    // clear coinciding with an EOF transfer
    push_pkt(2, 64'h300, 1);
    push_pkt(0, 64'h301, 1);
    push_word(1, 64'h302, 0, 0, 0);
    present();
    drain(4'b0111, 20);
    chk("t7_pre_cnt", PKT_CNT, 16'h0101);
    chk("t7_pre_err", ERR, 4'b0010);
    push_pkt(0, 64'h200, 2);
    present();
    tick();
    CNT_CLEAR = 1'b1;
    tick();
    CNT_CLEAR = 1'b0;
    #1;
    chk("t7_clear_eof_cnt", PKT_CNT, 16'h0001);
    chk("t7_clear_eof_err", ERR, 0);

    // clear coinciding with an orphan error
    push_pkt(2, 64'h310, 1);
    present();
    drain(4'b0100, 10);
    chk("t8_pre_cnt", PKT_CNT, 16'h0101);
    push_word(3, 64'h311, 0, 0, 1);
    present();
    CNT_CLEAR = 1'b1;
    tick();
    CNT_CLEAR = 1'b0;
    #1;
    chk("t8_clear_err", ERR, 4'b1000);
    chk("t8_clear_cnt", PKT_CNT, 0);

    // reset in the middle of a channel 2 packet
    push_pkt(2, 64'h400, 3);
    present();
    tick();
    RESET = 1'b1;
    #1;
    chk("t9_rst_tx_src", TX_SRC_RDY_N, 1);
    chk("t9_rst_rx_dst", RX_DST_RDY_N, 4'hF);
    chk("t9_rst_channel", TX_CHANNEL, 0);
    chk("t9_rst_cnt", PKT_CNT, 0);
    tick();
    for (int i = 0; i < N; i++) q[i].delete();
    present();
    RESET = 1'b0;
    b = txlog.size();
    push_pkt(3, 64'h500, 2);
    push_pkt(0, 64'h600, 2);
    present();
    drain(4'b1001, 20);
    log_is("t9a", b, 0, 64'h600, 0, b);
    log_is("t9b", b + 1, 0, 64'h601, 1, b);
    log_is("t9c", b + 2, 3, 64'h500, 2, b);
    log_is("t9d", b + 3, 3, 64'h501, 3, b);
    chk("t9_pkt_cnt", PKT_CNT, 16'h1001);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
